dmi_jtag_responder: RTL and testbench

DMI_JTAG_RESPONDER -- requirements
Module: dmi_jtag_responder

---
 rtl/dmi_jtag_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dmi_jtag_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_responder.sv
// JTAG DTM: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS registers and a DMI request/response port.
// Optional macro DMI_JTAG_TRST_EN lets a synchronised jtag_TRSTn low force the TAP into Test-Logic-Reset.
module dmi_jtag_responder #(
  parameter logic [31:0] IdCode        = 32'h249511C3,
  parameter int          MinSyncStages = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        jtag_TCK,
  input  logic        jtag_TMS,
  input  logic        jtag_TDI,
  input  logic        jtag_TRSTn,
  output logic        jtag_TDO_data,
  output logic        jtag_TDO_driven,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic        dmi_resp_err_i
);
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR,
    PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR,
    PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE   = 5'h01;
  localparam logic [4:0] IR_DTMCS    = 5'h10;
  localparam logic [4:0] IR_DMI      = 5'h11;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] STAT_FAILED = 2'd2;
  localparam logic [1:0] STAT_BUSY   = 2'd3;

  // Pin bundle order: {TRSTn, TDI, TMS, TCK}
  logic [3:0]  sync_q [MinSyncStages];
  logic [3:0]  pins_s;
  logic        tck_prev_q, tck_rise, tck_fall, tms_s, tdi_s, tap_rst;
  tap_state_e  tap_q, tap_d;
  logic        in_tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
  logic [4:0]  ir_q, ir_sh_q;
  logic [40:0] dr_q, dr_capture, dr_shifted;
  logic        tdo_q;
  logic        req_valid_q, resp_pending_q, busy;
  logic [1:0]  dmistat_q, dmi_status, op_q;
  logic [6:0]  addr_q;
  logic [31:0] data_q, dtmcs_capture;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MinSyncStages; i++) sync_q[i] <= 4'b1000;
      tck_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};
      for (int i = 1; i < MinSyncStages; i++) sync_q[i] <= sync_q[i-1];
      tck_prev_q <= pins_s[0];
    end
  end

  assign pins_s   = sync_q[MinSyncStages-1];
  assign tms_s    = pins_s[1];
  assign tdi_s    = pins_s[2];
  assign tck_rise = pins_s[0] & ~tck_prev_q;
  assign tck_fall = ~pins_s[0] & tck_prev_q;

`ifdef DMI_JTAG_TRST_EN
  assign tap_rst = ~pins_s[3];
`else
  logic unused_trstn;
  assign tap_rst      = 1'b0;
  assign unused_trstn = pins_s[3];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni || tap_rst) tap_q <= TEST_LOGIC_RESET;
    else if (tck_rise)      tap_q <= tap_d;
  end

  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TEST_LOGIC_RESET: tap_d = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    tap_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   tap_d = tms_s ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       tap_d = tms_s ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         tap_d = tms_s ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         tap_d = tms_s ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         tap_d = tms_s ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         tap_d = tms_s ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        tap_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   tap_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       tap_d = tms_s ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         tap_d = tms_s ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         tap_d = tms_s ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         tap_d = tms_s ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         tap_d = tms_s ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        tap_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          tap_d = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    in_tlr     = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    case (tap_q)
      TEST_LOGIC_RESET: in_tlr     = 1'b1;
      CAPTURE_DR:       capture_dr = 1'b1;
      SHIFT_DR:         shift_dr   = 1'b1;
      UPDATE_DR:        update_dr  = 1'b1;
      CAPTURE_IR:       capture_ir = 1'b1;
      SHIFT_IR:         shift_ir   = 1'b1;
      UPDATE_IR:        update_ir  = 1'b1;
      default:          ;
    endcase
  end

  assign jtag_TDO_driven = shift_dr | shift_ir;
  assign jtag_TDO_data   = tdo_q;

  assign busy          = req_valid_q | resp_pending_q;
  assign dmi_status    = (dmistat_q != 2'd0) ? dmistat_q : (busy ? STAT_BUSY : 2'd0);
  assign dtmcs_capture = {14'd0, 2'b00, 1'b0, 3'd1, dmistat_q, 6'd7, 4'd1};

  always_comb begin
    dr_capture = '0;
    dr_shifted = {40'd0, tdi_s};
    case (ir_q)
      IR_IDCODE: begin
        dr_capture = {9'd0, IdCode};
        dr_shifted = {9'd0, tdi_s, dr_q[31:1]};
      end
      IR_DTMCS: begin
        dr_capture = {9'd0, dtmcs_capture};
        dr_shifted = {9'd0, tdi_s, dr_q[31:1]};
      end
      IR_DMI: begin
        dr_capture = {addr_q, data_q, dmi_status};
        dr_shifted = {tdi_s, dr_q[40:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ir_q    <= IR_IDCODE;
      ir_sh_q <= '0;
      dr_q    <= '0;
      tdo_q   <= 1'b0;
    end else begin
      if (tap_rst || in_tlr)          ir_q <= IR_IDCODE;
      else if (tck_rise && update_ir) ir_q <= ir_sh_q;
      if (tck_rise && capture_ir)     ir_sh_q <= 5'b00001;
      else if (tck_rise && shift_ir)  ir_sh_q <= {tdi_s, ir_sh_q[4:1]};
      if (tck_rise && capture_dr)     dr_q <= dr_capture;
      else if (tck_rise && shift_dr)  dr_q <= dr_shifted;
      if (tck_fall && shift_ir)       tdo_q <= ir_sh_q[0];
      else if (tck_fall && shift_dr)  tdo_q <= dr_q[0];
    end
  end

  // Later assignments win: a same-cycle DM handshake overrides a DTM-side update.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_valid_q    <= 1'b0;
      resp_pending_q <= 1'b0;
      dmistat_q      <= 2'd0;
      addr_q         <= '0;
      data_q         <= '0;
      op_q           <= '0;
    end else begin
      if (tck_rise && capture_dr && ir_q == IR_DMI && busy && dmistat_q == 2'd0)
        dmistat_q <= STAT_BUSY;
      if (tck_rise && update_dr && ir_q == IR_DTMCS) begin
        if (dr_q[16] || dr_q[17]) dmistat_q   <= 2'd0;
        if (dr_q[17])             req_valid_q <= 1'b0;
      end
      if (tck_rise && update_dr && ir_q == IR_DMI && !busy && dmistat_q == 2'd0 &&
          (dr_q[1:0] == OP_READ || dr_q[1:0] == OP_WRITE)) begin
        req_valid_q <= 1'b1;
        addr_q      <= dr_q[40:34];
        data_q      <= dr_q[33:2];
        op_q        <= dr_q[1:0];
      end
      if (req_valid_q && dmi_req_ready_i) begin
        req_valid_q    <= 1'b0;
        resp_pending_q <= 1'b1;
      end
      if (resp_pending_q && dmi_resp_valid_i) begin
        resp_pending_q <= 1'b0;
        if (op_q == OP_READ) data_q <= dmi_resp_data_i;
        if (dmi_resp_err_i && dmistat_q == 2'd0) dmistat_q <= STAT_FAILED;
      end
    end
  end

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_resp_ready_o = busy;
endmodule

// File: tb/tb_dmi_jtag_responder.sv
// Bench for dmi_jtag_responder: JTAG driver tasks, a debug-module responder, and a
// field-level model of the DTM registers (last addr/data, sticky status).
module tb_dmi_jtag_responder;
  localparam logic [31:0] ID   = 32'h249511C3;
  localparam int          HALF = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i, dmi_resp_ready_o, dmi_resp_err_i;
  logic [31:0] dmi_resp_data_i;

  dmi_jtag_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o), .dmi_req_data_o(dmi_req_data_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_err_i(dmi_resp_err_i)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: observed no completion, expected $finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [40:0] exp_q[$];
  logic [40:0] req_log[$];
  int          resp_cnt = 0;
  int          exp_resp_cnt = 0;
  int          dm_ready_delay = 0;
  int          dm_resp_delay = 0;
  logic        dm_resp_err = 1'b0;
  logic [31:0] dm_resp_data = '0;

  // DTM reference model
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_dmistat = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [40:0] dmi_expect(input logic busy);
    logic [1:0] st;
    st = (m_dmistat != 2'd0) ? m_dmistat : (busy ? 2'd3 : 2'd0);
    return {m_addr, m_data, st};
  endfunction

  function automatic logic [31:0] dtmcs_expect(input logic [1:0] stat);
    return (32'd1 << 12) + (32'(stat) << 10) + (32'd7 << 4) + 32'd1;
  endfunction

  // ---------------- debug-module responder ----------------
  initial begin : dm_model
    logic [40:0] seen;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_err_i   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (dmi_req_valid_o === 1'b1) begin
        seen = {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o};
        for (int i = 0; i < dm_ready_delay; i++) begin
          @(negedge clk_i);
          check("req_hold", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
                64'({1'b1, seen}));
        end
        dmi_req_ready_i = 1'b1;
        @(negedge clk_i);
        dmi_req_ready_i = 1'b0;
        check("req_drop", 64'(dmi_req_valid_o), 64'(1'b0));
        req_log.push_back(seen);
        repeat (dm_resp_delay) @(negedge clk_i);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = dm_resp_data;
        dmi_resp_err_i   = dm_resp_err;
        @(negedge clk_i);
        dmi_resp_valid_i = 1'b0;
        dmi_resp_err_i   = 1'b0;
        resp_cnt++;
      end
    end
  end

  // ---------------- JTAG driver tasks ----------------
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    @(negedge clk_i);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (HALF) @(negedge clk_i);
    tdo = jtag_TDO_data;
    jtag_TCK = 1'b1;
    repeat (HALF) @(negedge clk_i);
    jtag_TCK = 1'b0;
  endtask

  task automatic ir_scan(input logic [4:0] ir);
    logic b;
    logic [4:0] cap;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, ir[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("ir_capture", 64'(cap), 64'(5'b00001));
  endtask

  task automatic dr_scan(input int n, input logic [40:0] din, output logic [40:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (resp_cnt < exp_resp_cnt && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 64'(resp_cnt), 64'(exp_resp_cnt));
  endtask

  task automatic sb_drain(input string tag);
    check({tag, "_count"}, 64'(req_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && req_log.size() > 0)
      check(tag, 64'(req_log.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    req_log.delete();
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin : main
    logic [40:0] dout;
    logic        b;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
    int          n;

    rst_ni = 1'b0;
    jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    repeat (4) @(negedge clk_i);
    check("rst_req_valid", 64'(dmi_req_valid_o), 64'(1'b0));
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'(1'b0));
    check("rst_tdo", 64'(jtag_TDO_data), 64'(1'b0));
    check("rst_tdo_driven", 64'(jtag_TDO_driven), 64'(1'b0));
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    tck_cycle(1'b0, 1'b0, b);
    dr_scan(32, 41'd0, dout);
    check("idcode", 64'(dout[31:0]), 64'(ID));

    ir_scan(5'h10);
    dr_scan(32, 41'd0, dout);
    check("dtmcs_reset", 64'(dout[31:0]), 64'(32'h00001071));

    ir_scan(5'h1F);
    dr_scan(2, 41'd1, dout);
    check("bypass", 64'(dout[1:0]), 64'(2'b10));

    // write addr 0x10 data 1, DM stalls ready to check payload holding
    ir_scan(5'h11);
    dm_ready_delay = 3; dm_resp_delay = 5; dm_resp_err = 1'b0; dm_resp_data = $urandom;
    dr_scan(41, {7'h10, 32'h1, 2'd2}, dout);
    check("dmi_first_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    exp_q.push_back({7'h10, 32'h1, 2'd2});
    exp_resp_cnt++;
    wait_resp("write_resp");
    sb_drain("write_req");
    m_addr = 7'h10; m_data = 32'h1;

    // slow read: rescan while outstanding sees busy and issues nothing
    dm_ready_delay = 0; dm_resp_delay = 200; dm_resp_data = $urandom;
    dr_scan(41, {7'h11, 32'h0, 2'd1}, dout);
    check("read_issue_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    exp_q.push_back({7'h11, 32'h0, 2'd1});
    exp_resp_cnt++;
    m_addr = 7'h11; m_data = 32'h0;
    dr_scan(41, {7'h11, 32'h0, 2'd1}, dout);
    check("busy_capture", 64'(dout), 64'(dmi_expect(1'b1)));
    if (m_dmistat == 2'd0) m_dmistat = 2'd3;
    wait_resp("read_resp");
    sb_drain("read_req");
    m_data = dm_resp_data;
    ir_scan(5'h10);
    dr_scan(32, 41'h0_0001_0000, dout);
    check("dtmcs_busy", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    m_dmistat = 2'd0;
    dr_scan(32, 41'd0, dout);
    check("dtmcs_cleared", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    ir_scan(5'h11);
    dr_scan(41, 41'd0, dout);
    check("read_data", 64'(dout), 64'(dmi_expect(1'b0)));

    // error response makes sticky status 2, which blocks requests until dmireset
    dm_resp_delay = 3; dm_resp_err = 1'b1; data = $urandom;
    dr_scan(41, {7'h05, data, 2'd2}, dout);
    check("err_issue_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    exp_q.push_back({7'h05, data, 2'd2});
    exp_resp_cnt++;
    wait_resp("err_resp");
    sb_drain("err_req");
    m_addr = 7'h05; m_data = data; m_dmistat = 2'd2;
    dm_resp_err = 1'b0;
    dr_scan(41, {7'h06, 32'h5a5a, 2'd2}, dout);
    check("err_block_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    repeat (30) @(negedge clk_i);
    sb_drain("err_block");
    ir_scan(5'h10);
    dr_scan(32, 41'd0, dout);
    check("dtmcs_err", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    dr_scan(32, 41'h0_0001_0000, dout);
    check("dtmcs_err_sticky", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    m_dmistat = 2'd0;
    dr_scan(32, 41'd0, dout);
    check("dtmcs_err_cleared", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    ir_scan(5'h11);

    // randomized DMI traffic against the model
    for (int it = 0; it < 16; it++) begin
      addr = 7'($urandom_range(0, 127));
      data = $urandom;
      op   = 2'($urandom_range(0, 3));
      dm_ready_delay = $urandom_range(0, 4);
      dm_resp_delay  = $urandom_range(0, 20);
      dm_resp_err    = ($urandom_range(0, 3) == 0);
      dm_resp_data   = $urandom;
      dr_scan(41, {addr, data, op}, dout);
      check("rand_capture", 64'(dout), 64'(dmi_expect(1'b0)));
      if ((op == 2'd1 || op == 2'd2) && m_dmistat == 2'd0) begin
        exp_q.push_back({addr, data, op});
        exp_resp_cnt++;
        wait_resp("rand_resp");
        m_addr = addr;
        m_data = (op == 2'd1) ? dm_resp_data : data;
        if (dm_resp_err) m_dmistat = 2'd2;
      end else begin
        repeat (30) @(negedge clk_i);
      end
      sb_drain("rand_req");
      if (m_dmistat != 2'd0 && $urandom_range(0, 1) == 1) begin
        ir_scan(5'h10);
        dr_scan(32, 41'h0_0001_0000, dout);
        check("rand_dtmcs", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
        m_dmistat = 2'd0;
        ir_scan(5'h11);
      end
    end
    dr_scan(41, 41'd0, dout);
    check("rand_final_capture", 64'(dout), 64'(dmi_expect(1'b0)));

    // TRSTn pulse in the middle of a DTMCS shift
    ir_scan(5'h10);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      tck_cycle(1'b0, 1'b0, b);
      dout[i] = b;
    end
    @(negedge clk_i);
    jtag_TRSTn = 1'b0;
    repeat (6) @(negedge clk_i);
    jtag_TRSTn = 1'b1;
    repeat (6) @(negedge clk_i);
`ifdef DMI_JTAG_TRST_EN
    check("trst_driven", 64'(jtag_TDO_driven), 64'(1'b0));
    tck_cycle(1'b0, 1'b0, b);
    dr_scan(32, 41'd0, dout);
    check("trst_idcode", 64'(dout[31:0]), 64'(ID));
`else
    check("trst_driven", 64'(jtag_TDO_driven), 64'(1'b1));
    for (int i = 8; i < 32; i++) begin
      tck_cycle(i == 31, 1'b0, b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("trst_ignored", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
`endif

    // system reset while a write is outstanding
    ir_scan(5'h10);
    dr_scan(32, 41'h0_0001_0000, dout);
    check("pre_rst_dtmcs", 64'(dout[31:0]), 64'(dtmcs_expect(m_dmistat)));
    m_dmistat = 2'd0;
    ir_scan(5'h11);
    dm_ready_delay = 0; dm_resp_delay = 150; dm_resp_err = 1'b0; dm_resp_data = $urandom;
    data = $urandom;
    dr_scan(41, {7'h22, data, 2'd2}, dout);
    check("pre_rst_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    exp_q.push_back({7'h22, data, 2'd2});
    exp_resp_cnt++;
    n = 0;
    while (req_log.size() == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("pre_rst_accept", 64'(req_log.size()), 64'(1));
    check("pre_rst_resp_ready", 64'(dmi_resp_ready_o), 64'(1'b1));
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("mid_rst_resp_ready", 64'(dmi_resp_ready_o), 64'(1'b0));
    check("mid_rst_req_valid", 64'(dmi_req_valid_o), 64'(1'b0));
    rst_ni = 1'b1;
    m_addr = '0; m_data = '0; m_dmistat = '0;
    tck_cycle(1'b0, 1'b0, b);
    dr_scan(32, 41'd0, dout);
    check("post_rst_idcode", 64'(dout[31:0]), 64'(ID));
    wait_resp("late_resp");
    check("post_rst_resp_ready", 64'(dmi_resp_ready_o), 64'(1'b0));
    ir_scan(5'h11);
    dr_scan(41, 41'd0, dout);
    check("post_rst_capture", 64'(dout), 64'(dmi_expect(1'b0)));
    sb_drain("rst_req");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
